// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, fetch tag record and pc-generator FSM encoding
// for the fetch front end.
package fetch_pkg;

  localparam int          XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } fetch_tag_t;

  typedef enum logic {
    FS_RUN,
    FS_FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: control inputs and fetch-address / retire outputs of the pc generator.
// The master side is the pc generator, the slave side is the fetch unit plus redirect source.
interface fetch_pc_gen_if;

  logic                      stall;
  logic                      redirect_valid;
  logic [fetch_pkg::XLEN-1:0] redirect_pc;
  logic [fetch_pkg::XLEN-1:0] pc;
  logic                      inst_valid;
  logic [fetch_pkg::XLEN-1:0] inst_pc;
  logic                      fetch_misalign;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output pc,
    output inst_valid,
    output inst_pc,
    output fetch_misalign
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  pc,
    input  inst_valid,
    input  inst_pc,
    input  fetch_misalign
  );

endinterface

// File: rtl/fetch_tag_pipe.sv
// fetch_tag_pipe: shift register of fetch tags that mirrors the fetch latency;
// flush drops the valid bit of every tag in flight on the same edge.
module fetch_tag_pipe
  import fetch_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  fetch_tag_t tag_in,
  output fetch_tag_t tag_out
);

  fetch_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      if (flush) stage[0].valid <= 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
        // Squashed tags keep shifting so inst_pc still tracks the bubble's pc.
        if (flush) stage[i].valid <= 1'b0;
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: pc register, next-pc mux and RUN/FAULT FSM ahead of the two-stage fetch unit.
// Misaligned-redirect faulting is built only when FETCH_MISALIGN_CHECK_EN is defined.
//
//   state    | meaning
//   FS_RUN   | launching one fetch per unstalled cycle, pc advances by 4
//   FS_FAULT | misaligned redirect taken; pc holds, no launches until an aligned redirect
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int              FETCH_LATENCY = 3
) (
  input logic            clk,
  input logic            reset_n,
  fetch_pc_gen_if.master bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;
  logic            misalign_q;
  fetch_tag_t      launch_tag;
  fetch_tag_t      retire_tag;

  always_comb begin
    launch_tag.valid = (state == FS_RUN) && !bus.stall && !bus.redirect_valid;
    launch_tag.pc    = pc_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q       <= RESET_VECTOR;
      state      <= FS_RUN;
      misalign_q <= 1'b0;
    end else if (bus.redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      pc_q <= bus.redirect_pc;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state      <= FS_FAULT;
        misalign_q <= 1'b1;
      end else begin
        state      <= FS_RUN;
        misalign_q <= 1'b0;
      end
`else
      pc_q       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      state      <= FS_RUN;
      misalign_q <= 1'b0;
`endif
    end else if (!bus.stall && state == FS_RUN) begin
      pc_q <= pc_q + XLEN'(INST_BYTES);
    end
  end

  fetch_tag_pipe #(
    .DEPTH (FETCH_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (bus.redirect_valid),
    .tag_in  (launch_tag),
    .tag_out (retire_tag)
  );

  assign bus.pc             = pc_q;
  assign bus.inst_valid     = retire_tag.valid;
  assign bus.inst_pc        = retire_tag.pc;
  assign bus.fetch_misalign = misalign_q;

endmodule
